// File: rtl/sha2_pkg.sv
// Shared SHA-256 definitions: FSM states, initial hash value and the
// bitwise round/schedule functions used by the core and message schedule.
package sha2_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [255:0] SHA2_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window whose head is W[t].
// Each shift drops W[t] and appends W[t+16], so only one new word is
// computed per cycle.
module sha2_msg_sched
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] message,
    output logic [31:0]  w
);

    logic [31:0] win [16];
    logic [31:0] w_new;

    // Window holds W[t..t+15]; the next word uses offsets 14, 9, 1 and 0.
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
    assign w     = win[0];

    // Load the block on LOAD, slide by one word per round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= message[511 - 32*i -: 32];
        end else if (shift) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha2.sv
// SHA-256 compression core, one round per clock. The K table lives outside
// and is addressed by t. hash exposes the raw working variables a..h; the
// caller adds the IV to form the digest.
module sha2
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] message,
    input  logic [31:0]  k,
    output logic [255:0] hash,
    output logic         done,
    output logic [5:0]   t
);

    state_t      state, state_nx;
    logic [5:0]  t_r;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w, t1, t2;

    sha2_msg_sched u_sched (
        .clk     (clk),
        .reset   (reset),
        .load    (state == LOAD),
        .shift   (state == ROUND),
        .message (message),
        .w       (w)
    );

    assign t1   = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2   = big_sigma0(a) + maj(a, b, c);
    assign hash = {a, b, c, d, e, f, g, h};
    assign done = (state == DONE);
    assign t    = t_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // Next state: one LOAD cycle, 64 rounds, then DONE until reset.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = ROUND;
            ROUND:   if (t_r == 6'd63) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = LOAD;
        endcase
    end

    // Working variables and round index; frozen outside ROUND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {a, b, c, d, e, f, g, h} <= SHA2_IV;
            t_r <= 6'd0;
        end else if (state == ROUND) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            if (t_r != 6'd63) t_r <= t_r + 6'd1;
        end
    end

endmodule

// File: tb/tb_sha2.sv
// Self-checking bench for the sha2 core with a behavioural SHA-256 model
// and a K ROM wired to the t output.
module tb_sha2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] message = '0;
    logic [31:0]  k;
    logic [255:0] hash;
    logic         done;
    logic [5:0]   t;

    int checks = 0;
    int failures = 0;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MSG_ALPHA = {
        32'h61626364, 32'h65666768, 32'h696a6b6c, 32'h6d6e6f70,
        32'h71727374, 32'h75767778, 32'h797a8000, 256'h0, 32'h000000d0
    };
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_ALPHA =
        256'h71c480df93d6ae2f1efad1447c66c9525e316218cf51fc8d9ed832f2daf18b73;

    assign k = K[t];

    always #5 clk = ~clk;

    sha2 dut (
        .clk     (clk),
        .reset   (reset),
        .message (message),
        .k       (k),
        .hash    (hash),
        .done    (done),
        .t       (t)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-block reference: full 64-word schedule array, then 64 rounds.
    function automatic logic [255:0] model(input logic [511:0] m);
        logic [31:0] W [64];
        logic [31:0] v [8];
        logic [31:0] s1, s0, x1, x2;
        for (int i = 0; i < 16; i++) W[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(W[i-15], 7) ^ rr(W[i-15], 18) ^ (W[i-15] >> 3);
            s1 = rr(W[i-2], 17) ^ rr(W[i-2], 19) ^ (W[i-2] >> 10);
            W[i] = s1 + W[i-7] + s0 + W[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = IV[255 - 32*i -: 32];
        for (int r = 0; r < 64; r++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[r] + W[r];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    function automatic logic [255:0] add_iv(input logic [255:0] x);
        logic [255:0] o;
        for (int i = 0; i < 8; i++)
            o[255 - 32*i -: 32] = x[255 - 32*i -: 32] + IV[255 - 32*i -: 32];
        return o;
    endfunction

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = $urandom();
        return m;
    endfunction

    // Reset, release, and step edges until done (bounded). Records the edge
    // on which done appeared and how many edges showed a wrong t/done.
    task automatic run_block(input logic [511:0] m, input bit scramble, input int abort_at,
                             output int done_edge, output int t_bad);
        int exp_t;
        done_edge = 0;
        t_bad = 0;
        reset = 1'b1;
        message = m;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            exp_t = (n == 1) ? 0 : ((n - 1 > 63) ? 63 : n - 1);
            if (t !== 6'(exp_t) || done !== (n >= 65)) t_bad++;
            if (scramble && n == 1) message = rand_msg();
            if (n == abort_at) return;
            if (done === 1'b1) begin
                done_edge = n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        message = MSG_ABC;
        repeat (2) @(negedge clk);
        checks++; if (hash !== IV) begin failures++; $display("FAIL reset_hash got=%h exp=%h", hash, IV); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (t !== 6'd0) begin failures++; $display("FAIL reset_t got=%0d exp=0", t); end
    endtask

    task automatic test_abc();
        int de, tb;
        run_block(MSG_ABC, 1'b0, 0, de, tb);
        checks++; if (de != 65) begin failures++; $display("FAIL abc_done_edge got=%0d exp=65", de); end
        checks++; if (tb != 0) begin failures++; $display("FAIL abc_t_sequence bad_edges=%0d exp=0", tb); end
        checks++; if (add_iv(hash) !== DIG_ABC) begin failures++; $display("FAIL abc_digest got=%h exp=%h", add_iv(hash), DIG_ABC); end
        checks++; if (hash !== model(MSG_ABC)) begin failures++; $display("FAIL abc_raw got=%h exp=%h", hash, model(MSG_ABC)); end
    endtask

    task automatic test_alpha();
        int de, tb;
        run_block(MSG_ALPHA, 1'b0, 0, de, tb);
        checks++; if (de != 65) begin failures++; $display("FAIL alpha_done_edge got=%0d exp=65", de); end
        checks++; if (add_iv(hash) !== DIG_ALPHA) begin failures++; $display("FAIL alpha_digest got=%h exp=%h", add_iv(hash), DIG_ALPHA); end
        checks++; if (hash[255:224] !== 32'h07ba9a78) begin failures++; $display("FAIL alpha_a got=%h exp=07ba9a78", hash[255:224]); end
    endtask

    task automatic test_hold();
        logic [255:0] h0;
        h0 = hash;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || hash !== h0 || t !== 6'd63) begin
                failures++;
                $display("FAIL hold cyc=%0d done=%b t=%0d hash=%h exp done=1 t=63 hash=%h", i, done, t, hash, h0);
            end
        end
    endtask

    task automatic test_abort();
        int de, tb;
        run_block(rand_msg(), 1'b0, 31, de, tb);
        checks++; if (tb != 0 || t !== 6'd30) begin failures++; $display("FAIL abort_pre t=%0d bad=%0d exp t=30 bad=0", t, tb); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hash !== IV || t !== 6'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_async hash=%h t=%0d done=%b exp hash=IV t=0 done=0", hash, t, done);
        end
        run_block(MSG_ABC, 1'b0, 0, de, tb);
        checks++; if (de != 65) begin failures++; $display("FAIL abort_done_edge got=%0d exp=65", de); end
        checks++; if (add_iv(hash) !== DIG_ABC) begin failures++; $display("FAIL abort_digest got=%h exp=%h", add_iv(hash), DIG_ABC); end
    endtask

    task automatic test_scramble();
        int de, tb;
        run_block(MSG_ABC, 1'b1, 0, de, tb);
        checks++; if (add_iv(hash) !== DIG_ABC || de != 65) begin failures++; $display("FAIL scramble_digest got=%h edge=%0d exp=%h edge=65", add_iv(hash), de, DIG_ABC); end
    endtask

    task automatic test_random();
        int de, tb;
        logic [511:0] m;
        logic [255:0] exp_h;
        for (int i = 0; i < 5; i++) begin
            m = rand_msg();
            exp_h = model(m);
            run_block(m, 1'b0, 0, de, tb);
            checks++; if (hash !== exp_h) begin failures++; $display("FAIL random%0d_hash got=%h exp=%h", i, hash, exp_h); end
            checks++; if (de != 65 || tb != 0) begin failures++; $display("FAIL random%0d_timing edge=%0d bad=%0d exp edge=65 bad=0", i, de, tb); end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_hold();
        test_alpha();
        test_abort();
        test_scramble();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha2.md
SHA2 -- requirements
Module: sha2

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by SHA-256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hash  output  256  working variables {a,b,c,d,e,f,g,h}, a in [255:224], h in [31:0].
REQ-005 done  output  1  high when the 64 rounds are complete; hash is then final.
REQ-006 t  output  6  current round index; the external K ROM is addressed by t.
REQ-007 k  input  32  round constant K[t]; combinationally returned by the external ROM in the same cycle as t.
REQ-008 message  input  512  one pre-padded block, big-endian; word 0 = message[511:480]; held stable from reset release until done.

Function
REQ-009 The block SHALL compute one SHA-256 compression of message starting from the standard IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19).
REQ-010 hash SHALL be the raw final a..h; the IV feed-forward addition is NOT applied inside the block.
REQ-011 State machine SHALL have states LOAD, ROUND, DONE; reset enters LOAD.
REQ-012 LOAD SHALL last exactly one cycle: on that edge, load message words 0..15 into a 16-word schedule window, keep t=0, and go to ROUND.
REQ-013 ROUND SHALL execute one round per cycle using k and W[t]; t increments each cycle from 0 to 63.
REQ-014 W[t] for t<16 SHALL be message word t; for t>=16, W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
REQ-015 The schedule SHALL be a sliding 16-entry shift register; only one new word is computed per cycle.
REQ-016 Round update SHALL be T1=h+Sigma1(e)+Ch(e,f,g)+k+W[t], T2=Sigma0(a)+Maj(a,b,c), with all additions mod 2^32.
REQ-017 The variables SHALL then update as h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
REQ-018 Sigma0 SHALL be ROTR2^ROTR13^ROTR22, Sigma1 ROTR6^ROTR11^ROTR25, sigma0 ROTR7^ROTR18^SHR3, and sigma1 ROTR17^ROTR19^SHR10.
REQ-019 After the edge that executes round 63, the block SHALL enter DONE, assert done, freeze hash, and hold t at 63.
REQ-020 DONE SHALL persist, with done high and hash stable, until reset.
REQ-021 done SHALL rise on the 65th rising clk edge after reset deasserts.
REQ-022 Message changes after the LOAD edge SHALL be ignored.
REQ-023 The design SHALL close timing at a 6.5 ns clock period.

Reset
REQ-024 Reset SHALL asynchronously set hash to the IV, done=0, t=0, state=LOAD, and the schedule window to 0.
REQ-025 Reset asserted mid-operation SHALL abort the computation, and the block SHALL restart from LOAD once reset is released.

Structure
REQ-026 A shared package sha2_pkg SHALL hold the IV constants, the state enumeration, and the Sigma0/Sigma1/sigma0/sigma1/Ch/Maj functions.
REQ-027 The message schedule SHALL be one sub-module, sha2_msg_sched (window, W[t] output, next-word logic).
REQ-028 The K table SHALL stay outside the block.

Verification
REQ-029 Message "abc" padded (61626380 0...0 00000018), K ROM connected -> done at edge 65, and hash+IV = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-030 Message "abcdefghijklmnopqrstuvwxyz" padded (length d0) -> hash+IV = 71c480df93d6ae2f1efad1447c66c9525e316218cf51fc8d9ed832f2daf18b73, and hash[255:224] = 07ba9a78.
REQ-031 Hold for 10 cycles after done -> done stays 1, hash stays unchanged, t stays 63.
REQ-032 Assert reset at round 30, release, run the "abc" vector -> same digest as REQ-029, done again 65 edges after release.
REQ-033 During reset -> hash = IV, done=0, t=0; t sequence is 0 (LOAD), 0..63 in ROUND, then holds 63.
REQ-034 Change message after the LOAD edge -> digest unchanged.
